// File: rtl/regfile_writeback_if.sv
// Writeback bus bundle: ALU result, load result, register-file write port
// and the decode-side hazard query.
interface regfile_writeback_if #(
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          aluValid;
  logic [4:0]    aluRd;
  logic [63:0]   aluResult;
  logic          aluReady;

  logic          memValid;
  logic [4:0]    memRd;
  logic [63:0]   memData;
  logic          memReady;

  logic [4:0]    writeReg;
  logic [63:0]   writeData;
  logic          regWrite;

  logic [4:0]    readReg1;
  logic [4:0]    readReg2;
  logic          pendHit1;
  logic          pendHit2;
  logic [CW-1:0] pendCount;

  // Producer / decode side
  modport master (
    output aluValid, aluRd, aluResult,
    output memValid, memRd, memData,
    output readReg1, readReg2,
    input  aluReady, memReady,
    input  writeReg, writeData, regWrite,
    input  pendHit1, pendHit2, pendCount
  );

  // Writeback arbiter side
  modport slave (
    input  aluValid, aluRd, aluResult,
    input  memValid, memRd, memData,
    input  readReg1, readReg2,
    output aluReady, memReady,
    output writeReg, writeData, regWrite,
    output pendHit1, pendHit2, pendCount
  );
endinterface

// File: rtl/regfile_writeback.sv
// Register-file writeback arbiter. ALU results write straight through;
// load results are queued in a small FIFO and drain when the ALU is idle.
// A starvation counter forces the queue head through after the ALU has
// won STARVE_LIMIT times in a row against a non-empty queue. x0 targets
// are consumed without a write strobe.
module regfile_writeback #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 3
) (
  input logic               clk,
  input logic               rst_n,
  regfile_writeback_if.slave wb
);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 2);
  localparam logic [PW:0]   DEPTH_CNT  = (PW + 1)'(DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [4:0]       qRd   [DEPTH];
  logic [63:0]      qData [DEPTH];
  logic [DEPTH-1:0] qValid;
  logic [PW-1:0]    rdPtr;
  logic [PW-1:0]    wrPtr;
  logic [PW:0]      count;
  logic [SW-1:0]    starveCnt;

  logic             queueEmpty;
  logic             queueHasRoom;
  logic             forceLoad;
  logic             aluAccept;
  logic             push;
  logic             pop;
  logic             winValid;
  logic [4:0]       winRd;
  logic [63:0]      winData;

  logic             regWriteQ;
  logic [4:0]       writeRegQ;
  logic [63:0]      writeDataQ;
  logic             hit1;
  logic             hit2;

  // Arbitration: all decisions come from start-of-cycle state only.
  always_comb begin
    queueEmpty   = (count == '0);
    queueHasRoom = (count < DEPTH_CNT);
    forceLoad    = !queueEmpty && (starveCnt == STARVE_MAX);
    aluAccept    = wb.aluValid && !forceLoad;
    push         = wb.memValid && queueHasRoom;
    pop          = !aluAccept && !queueEmpty;
    winValid     = aluAccept || pop;
    winRd        = aluAccept ? wb.aluRd     : qRd[rdPtr];
    winData      = aluAccept ? wb.aluResult : qData[rdPtr];
  end

  // Queue payload storage; validity is tracked separately so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push) begin
      qRd[wrPtr]   <= wb.memRd;
      qData[wrPtr] <= wb.memData;
    end
  end

  // Queue pointers, occupancy and per-entry valid flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr  <= '0;
      wrPtr  <= '0;
      count  <= '0;
      qValid <= '0;
    end else begin
      if (pop) begin
        qValid[rdPtr] <= 1'b0;
        rdPtr         <= rdPtr + PW'(1);
      end
      if (push) begin
        qValid[wrPtr] <= 1'b1;
        wrPtr         <= wrPtr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PW + 1)'(1);
        2'b01:   count <= count - (PW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Starvation counter: counts ALU wins against a waiting queue head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starveCnt <= '0;
    end else if (queueEmpty || pop) begin
      starveCnt <= '0;
    end else if (aluAccept) begin
      starveCnt <= starveCnt + SW'(1);
    end
  end

  // Registered write port; x0 winners are consumed but never strobed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regWriteQ  <= 1'b0;
      writeRegQ  <= '0;
      writeDataQ <= '0;
    end else if (winValid) begin
      regWriteQ <= (winRd != 5'd0);
      if (winRd != 5'd0) begin
        writeRegQ  <= winRd;
        writeDataQ <= winData;
      end
    end else begin
      regWriteQ <= 1'b0;
    end
  end

  // Hazard query: any queued destination or the write currently on the port.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (qValid[i] && (qRd[i] == wb.readReg1)) hit1 = 1'b1;
      if (qValid[i] && (qRd[i] == wb.readReg2)) hit2 = 1'b1;
    end
    if (regWriteQ && (writeRegQ == wb.readReg1)) hit1 = 1'b1;
    if (regWriteQ && (writeRegQ == wb.readReg2)) hit2 = 1'b1;
    if (wb.readReg1 == 5'd0) hit1 = 1'b0;
    if (wb.readReg2 == 5'd0) hit2 = 1'b0;
  end

  assign wb.aluReady  = !forceLoad;
  assign wb.memReady  = queueHasRoom;
  assign wb.pendCount = count;
  assign wb.regWrite  = regWriteQ;
  assign wb.writeReg  = writeRegQ;
  assign wb.writeData = writeDataQ;
  assign wb.pendHit1  = hit1;
  assign wb.pendHit2  = hit2;
endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios plus a randomized run,
// all checked against a queue-based reference model.
module tb_regfile_writeback;
  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 3;

  logic clk = 1'b0;
  logic rst_n;

  regfile_writeback_if #(.DEPTH(DEPTH)) wb();

  regfile_writeback #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wb)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } entryT;

  // Reference model state
  entryT       mQ[$];
  int          mStarve;
  logic        mRegWrite;
  logic [4:0]  mWriteReg;
  logic [63:0] mWriteData;

  // Model expectations for the combinational outputs
  logic        eAluReady, eMemReady, eHit1, eHit2;
  logic [31:0] ePendCount;

  // DUT samples
  logic        sAluReady, sMemReady, sHit1, sHit2;
  logic [31:0] sPendCount;
  logic        sRegWrite;
  logic [4:0]  sWriteReg;
  logic [63:0] sWriteData;

  logic [4:0]  rdA, rdB;
  int compared   = 0;
  int mismatched = 0;

  function automatic logic modelHit(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (mRegWrite && mWriteReg == r) return 1'b1;
    foreach (mQ[i]) if (mQ[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void modelReset();
    mQ.delete();
    mStarve    = 0;
    mRegWrite  = 1'b0;
    mWriteReg  = '0;
    mWriteData = '0;
  endfunction

  function automatic void modelComb();
    eAluReady  = !(mQ.size() > 0 && mStarve == STARVE_LIMIT);
    eMemReady  = (mQ.size() < DEPTH);
    ePendCount = 32'(mQ.size());
    eHit1      = modelHit(rdA);
    eHit2      = modelHit(rdB);
  endfunction

  function automatic void modelClock(input logic av, input logic [4:0] ard, input logic [63:0] ares,
                                     input logic mv, input logic [4:0] mrd, input logic [63:0] md);
    bit    hadEntries = (mQ.size() > 0);
    bit    forced     = hadEntries && (mStarve == STARVE_LIMIT);
    bit    aluWin     = av && !forced;
    bit    pushOk     = mv && (mQ.size() < DEPTH);
    bit    popped     = 0;
    bit    haveWin    = 0;
    entryT w;
    w = '0;
    if (aluWin) begin
      w.rd = ard; w.data = ares; haveWin = 1;
    end else if (hadEntries) begin
      w = mQ.pop_front(); haveWin = 1; popped = 1;
    end
    if (!hadEntries || popped) mStarve = 0;
    else if (aluWin) mStarve++;
    if (pushOk) mQ.push_back({mrd, md});
    if (haveWin && w.rd != 5'd0) begin
      mRegWrite = 1'b1; mWriteReg = w.rd; mWriteData = w.data;
    end else begin
      mRegWrite = 1'b0;
    end
  endfunction

  task automatic setRead(input logic [4:0] a, input logic [4:0] b);
    rdA = a; rdB = b;
    wb.readReg1 = a; wb.readReg2 = b;
  endtask

  // One clock of stimulus: samples combinational outputs at the falling edge
  // and registered outputs 1 time unit after the rising edge.
  task automatic cycle(input logic av, input logic [4:0] ard, input logic [63:0] ares,
                       input logic mv, input logic [4:0] mrd, input logic [63:0] md);
    wb.aluValid = av; wb.aluRd = ard; wb.aluResult = ares;
    wb.memValid = mv; wb.memRd = mrd; wb.memData = md;
    @(negedge clk);
    modelComb();
    sAluReady  = wb.aluReady;
    sMemReady  = wb.memReady;
    sPendCount = 32'(wb.pendCount);
    sHit1      = wb.pendHit1;
    sHit2      = wb.pendHit2;
    @(posedge clk);
    modelClock(av, ard, ares, mv, mrd, md);
    #1;
    sRegWrite  = wb.regWrite;
    sWriteReg  = wb.writeReg;
    sWriteData = wb.writeData;
  endtask

  task automatic idle();
    cycle(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    setRead(5'd0, 5'd0);
    wb.aluValid = 1'b0; wb.aluRd = '0; wb.aluResult = '0;
    wb.memValid = 1'b0; wb.memRd = '0; wb.memData = '0;
    modelReset();
    #1;
    compared++;
    if (wb.regWrite !== 1'b0 || wb.writeReg !== 5'd0 || wb.writeData !== 64'd0) begin
      mismatched++;
      $display("FAIL reset_writePort: got regWrite=%b writeReg=%0d writeData=%h expected 0/0/0",
               wb.regWrite, wb.writeReg, wb.writeData);
    end
    compared++;
    if (wb.pendCount !== '0) begin
      mismatched++;
      $display("FAIL reset_pendCount: got %0d expected 0", wb.pendCount);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    compared++;
    if (wb.aluReady !== 1'b1 || wb.memReady !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_ready: got aluReady=%b memReady=%b expected 1/1", wb.aluReady, wb.memReady);
    end
  endtask

  task automatic test_alu_single();
    cycle(1'b1, 5'd5, 64'hDEAD, 1'b0, 5'd0, 64'd0);
    compared++;
    if (sRegWrite !== 1'b1 || sWriteReg !== 5'd5 || sWriteData !== 64'hDEAD) begin
      mismatched++;
      $display("FAIL alu_single: got regWrite=%b writeReg=%0d writeData=%h expected 1/5/dead",
               sRegWrite, sWriteReg, sWriteData);
    end
    idle();
    compared++;
    if (sRegWrite !== 1'b0 || sWriteReg !== 5'd5 || sWriteData !== 64'hDEAD) begin
      mismatched++;
      $display("FAIL alu_idle_hold: got regWrite=%b writeReg=%0d writeData=%h expected 0/5/dead",
               sRegWrite, sWriteReg, sWriteData);
    end
  endtask

  task automatic test_fill_queue();
    cycle(1'b1, 5'd1, 64'h11, 1'b1, 5'd7, 64'h70);
    cycle(1'b1, 5'd2, 64'h22, 1'b1, 5'd8, 64'h80);
    cycle(1'b1, 5'd3, 64'h33, 1'b1, 5'd9, 64'h90);
    compared++;
    if (sMemReady !== 1'b0 || sPendCount !== 32'd2) begin
      mismatched++;
      $display("FAIL fill_full: got memReady=%b pendCount=%0d expected 0/2", sMemReady, sPendCount);
    end
    idle();
    compared++;
    if (sRegWrite !== 1'b1 || sWriteReg !== 5'd7 || sWriteData !== 64'h70) begin
      mismatched++;
      $display("FAIL fill_first: got regWrite=%b writeReg=%0d writeData=%h expected 1/7/70",
               sRegWrite, sWriteReg, sWriteData);
    end
    idle();
    compared++;
    if (sRegWrite !== 1'b1 || sWriteReg !== 5'd8 || sWriteData !== 64'h80) begin
      mismatched++;
      $display("FAIL fill_second: got regWrite=%b writeReg=%0d writeData=%h expected 1/8/80",
               sRegWrite, sWriteReg, sWriteData);
    end
    idle();
    compared++;
    if (sRegWrite !== 1'b0 || sPendCount !== 32'd0) begin
      mismatched++;
      $display("FAIL fill_drained: got regWrite=%b pendCount=%0d expected 0/0", sRegWrite, sPendCount);
    end
  endtask

  task automatic test_starvation();
    cycle(1'b1, 5'd10, 64'hA0, 1'b1, 5'd9, 64'h99);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 5'(11 + i), 64'(16'hB0 + i), 1'b0, 5'd0, 64'd0);
      compared++;
      if (sAluReady !== 1'b1 || sRegWrite !== 1'b1 || sWriteReg !== 5'(11 + i)) begin
        mismatched++;
        $display("FAIL starve_aluWin%0d: got aluReady=%b regWrite=%b writeReg=%0d expected 1/1/%0d",
                 i, sAluReady, sRegWrite, sWriteReg, 11 + i);
      end
    end
    cycle(1'b1, 5'd14, 64'hE0, 1'b0, 5'd0, 64'd0);
    compared++;
    if (sAluReady !== 1'b0 || sRegWrite !== 1'b1 || sWriteReg !== 5'd9 || sWriteData !== 64'h99) begin
      mismatched++;
      $display("FAIL starve_forced: got aluReady=%b regWrite=%b writeReg=%0d writeData=%h expected 0/1/9/99",
               sAluReady, sRegWrite, sWriteReg, sWriteData);
    end
    cycle(1'b1, 5'd15, 64'hF0, 1'b0, 5'd0, 64'd0);
    compared++;
    if (sAluReady !== 1'b1 || sWriteReg !== 5'd15 || sPendCount !== 32'd0) begin
      mismatched++;
      $display("FAIL starve_cleared: got aluReady=%b writeReg=%0d pendCount=%0d expected 1/15/0",
               sAluReady, sWriteReg, sPendCount);
    end
    idle();
  endtask

  task automatic test_x0_drop();
    cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'h1234);
    cycle(1'b1, 5'd3, 64'h333, 1'b0, 5'd0, 64'd0);
    compared++;
    if (sRegWrite !== 1'b1 || sWriteReg !== 5'd3 || sWriteData !== 64'h333) begin
      mismatched++;
      $display("FAIL x0_aluWrite: got regWrite=%b writeReg=%0d writeData=%h expected 1/3/333",
               sRegWrite, sWriteReg, sWriteData);
    end
    idle();
    compared++;
    if (sRegWrite !== 1'b0 || sWriteReg !== 5'd3 || sWriteData !== 64'h333) begin
      mismatched++;
      $display("FAIL x0_noStrobe: got regWrite=%b writeReg=%0d writeData=%h expected 0/3/333",
               sRegWrite, sWriteReg, sWriteData);
    end
    idle();
    compared++;
    if (sPendCount !== 32'd0) begin
      mismatched++;
      $display("FAIL x0_pendCount: got %0d expected 0", sPendCount);
    end
  endtask

  task automatic test_hazard();
    cycle(1'b1, 5'd1, 64'h1, 1'b1, 5'd12, 64'hC0);
    cycle(1'b1, 5'd2, 64'h2, 1'b1, 5'd0, 64'hC1);
    setRead(5'd12, 5'd0);
    cycle(1'b1, 5'd4, 64'h44, 1'b0, 5'd0, 64'd0);
    compared++;
    if (sHit1 !== 1'b1 || sHit2 !== 1'b0 || sPendCount !== 32'd2) begin
      mismatched++;
      $display("FAIL hazard_queue: got pendHit1=%b pendHit2=%b pendCount=%0d expected 1/0/2",
               sHit1, sHit2, sPendCount);
    end
    setRead(5'd13, 5'd4);
    cycle(1'b1, 5'd5, 64'h55, 1'b0, 5'd0, 64'd0);
    compared++;
    if (sHit1 !== 1'b0 || sHit2 !== 1'b1) begin
      mismatched++;
      $display("FAIL hazard_writePort: got pendHit1=%b pendHit2=%b expected 0/1", sHit1, sHit2);
    end
    setRead(5'd0, 5'd0);
    repeat (3) idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      setRead(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      cycle(1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), {$urandom, $urandom},
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom});
      compared++;
      if (sAluReady !== eAluReady || sMemReady !== eMemReady) begin
        mismatched++;
        $display("FAIL rand_ready cycle %0d: got aluReady=%b memReady=%b expected %b/%b",
                 n, sAluReady, sMemReady, eAluReady, eMemReady);
      end
      compared++;
      if (sPendCount !== ePendCount) begin
        mismatched++;
        $display("FAIL rand_pendCount cycle %0d: got %0d expected %0d", n, sPendCount, ePendCount);
      end
      compared++;
      if (sHit1 !== eHit1 || sHit2 !== eHit2) begin
        mismatched++;
        $display("FAIL rand_pendHit cycle %0d: got %b/%b expected %b/%b", n, sHit1, sHit2, eHit1, eHit2);
      end
      compared++;
      if (sRegWrite !== mRegWrite || sWriteReg !== mWriteReg || sWriteData !== mWriteData) begin
        mismatched++;
        $display("FAIL rand_write cycle %0d: got %b/%0d/%h expected %b/%0d/%h",
                 n, sRegWrite, sWriteReg, sWriteData, mRegWrite, mWriteReg, mWriteData);
      end
    end
    setRead(5'd0, 5'd0);
    repeat (3) idle();
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 5'd6, 64'h66, 1'b1, 5'd7, 64'h77);
    cycle(1'b1, 5'd11, 64'hBB, 1'b1, 5'd8, 64'h88);
    compared++;
    if (sRegWrite !== 1'b1 || sWriteReg !== 5'd11) begin
      mismatched++;
      $display("FAIL resetMid_preWrite: got regWrite=%b writeReg=%0d expected 1/11", sRegWrite, sWriteReg);
    end
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    compared++;
    if (wb.regWrite !== 1'b0 || wb.pendCount !== '0 || wb.writeReg !== 5'd0 || wb.writeData !== 64'd0) begin
      mismatched++;
      $display("FAIL resetMid_async: got regWrite=%b pendCount=%0d writeReg=%0d writeData=%h expected 0/0/0/0",
               wb.regWrite, wb.pendCount, wb.writeReg, wb.writeData);
    end
    wb.aluValid = 1'b0; wb.memValid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    compared++;
    if (wb.aluReady !== 1'b1 || wb.memReady !== 1'b1) begin
      mismatched++;
      $display("FAIL resetMid_ready: got aluReady=%b memReady=%b expected 1/1", wb.aluReady, wb.memReady);
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      compared++;
      if (sRegWrite !== 1'b0 || sPendCount !== 32'd0) begin
        mismatched++;
        $display("FAIL resetMid_stale%0d: got regWrite=%b pendCount=%0d expected 0/0", i, sRegWrite, sPendCount);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_single();
    test_fill_queue();
    test_starvation();
    test_x0_drop();
    test_hazard();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 SHALL have parameter DEPTH, default 2, giving the number of load-result queue entries (power of 2, at least 2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 3, giving the number of consecutive cycles a queued load may lose arbitration before it is forced.
REQ-003 SHALL have one clock and an asynchronous, active-low reset:
- clk  in  1  clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have the ALU result ports:
- aluValid  in  1  an ALU result is presented.
- aluRd  in  5  ALU destination register.
- aluResult  in  64  ALU result data.
- aluReady  out  1  ALU result is accepted this cycle.
REQ-005 SHALL have the load result ports:
- memValid  in  1  a load result is presented.
- memRd  in  5  load destination register.
- memData  in  64  load result data.
- memReady  out  1  the queue can accept a load this cycle.
REQ-006 SHALL have the register file write port:
- writeReg  out  5  write address to the register file.
- writeData  out  64  write data to the register file.
- regWrite  out  1  write strobe to the register file.
REQ-007 SHALL have the hazard query ports:
- readReg1  in  5  decode source register 1.
- readReg2  in  5  decode source register 2.
- pendHit1  out  1  source register 1 has a write in flight.
- pendHit2  out  1  source register 2 has a write in flight.
- pendCount  out  clog2(DEPTH)+1  number of occupied queue entries.

Function
REQ-008 SHALL accept a load when memValid=1 and memReady=1, pushing {memRd, memData} into the FIFO queue.
REQ-009 SHALL drive memReady = (pendCount < DEPTH), evaluated from the start-of-cycle state only; a pop in the same cycle does not free space for a push.
REQ-010 SHALL accept an ALU result when aluValid=1 and aluReady=1.
REQ-011 SHALL drive aluReady low only while the forced-load condition of REQ-015 holds, and high otherwise.
REQ-012 SHALL select at most one winner per cycle, in this priority order:
- accepted ALU result;
- otherwise the queue head, if the queue is non-empty.
REQ-013 SHALL register the winner into writeReg/writeData with regWrite=1 on the next edge, giving 1-cycle latency; when there is no winner, regWrite=0 and writeReg/writeData hold their previous values.
REQ-014 SHALL consume a winner whose destination is x0 (a register value of 0), including popping it from the queue, while driving regWrite=0.
REQ-015 SHALL maintain a starvation counter:
- increment when the queue is non-empty and the ALU wins;
- clear on any queue pop or when the queue is empty;
- when the counter equals STARVE_LIMIT, aluReady=0 and the queue head wins.
REQ-016 SHALL preserve FIFO order, and SHALL wrap the read and write pointers modulo DEPTH.
REQ-017 SHALL, on a simultaneous push and pop when not full, update pendCount by net zero, and pop the old head.
REQ-018 SHALL assert pendHitN combinationally when readRegN != 0 and readRegN matches either of:
- any valid queue entry's destination;
- writeReg while regWrite=1.
REQ-019 SHALL keep a newer ALU write and an older queued load to the same register ordered by arrival; the hazard check covers this because the load stays pending.

Reset
REQ-020 SHALL, while rst_n=0, immediately force all of the following, regardless of clk:
- regWrite=0, writeReg=0, writeData=0;
- queue empty, pendCount=0;
- starvation counter=0.
REQ-021 SHALL discard any queued or in-flight writes on reset assertion mid-operation.
REQ-022 SHALL drive memReady=1 and aluReady=1 from the first cycle after deassertion.

Verification
REQ-023 Single ALU write: aluValid=1, aluRd=5, aluResult=0xDEAD -> on the next cycle regWrite=1, writeReg=5, writeData=0xDEAD.
REQ-024 Fill the queue: loads to x7 then x8 with no ALU traffic -> x7 is written, then x8, in consecutive cycles; with DEPTH=2 and ALU busy, memReady=0 after the second load.
REQ-025 Starvation: queue holds a load to x9 while the ALU is valid every cycle -> after 3 ALU wins, aluReady=0 for one cycle and x9 is written; the counter then clears.
REQ-026 x0 drop: load to x0 followed by ALU to x3 -> no regWrite for x0, pendCount returns to 0, and x3 is written normally.
REQ-027 Hazard query: queue holds x12 and readReg1=12 -> pendHit1=1; with readReg2=0 -> pendHit2=0 even if an x0 entry is queued.
REQ-028 Reset mid-operation: two queued loads and an active write, then rst_n=0 -> regWrite=0 and pendCount=0 immediately; after release, no stale write appears.
